// File: rtl/packed_mac_accumulator_pkg.sv
// Shared definitions for the packed MAC accumulator.
// Holds the lane layout of the packed product word, the lane split helper
// and the requantization function (round-half-up, arithmetic shift,
// saturate, optional ReLU).
package packed_mac_accumulator_pkg;

   localparam int M_WIDTH    = 32;
   localparam int LANE_WIDTH = 16;
   localparam int LANE0_LSB  = 0;
   localparam int LANE1_LSB  = 16;
   localparam int NUM_LANES  = 2;

   typedef struct packed {
      logic signed [LANE_WIDTH-1:0] lane1;
      logic signed [LANE_WIDTH-1:0] lane0;
   } lane_pair_t;

   function automatic lane_pair_t lane_split(input logic [M_WIDTH-1:0] m);
      lane_pair_t p;
      p.lane0 = m[LANE0_LSB +: LANE_WIDTH];
      p.lane1 = m[LANE1_LSB +: LANE_WIDTH];
      return p;
   endfunction

   // Works in a 64-bit domain so the rounding add can never overflow an
   // accumulator of up to 63 bits; caller truncates to its output width.
   function automatic logic signed [31:0] requant(input logic signed [63:0] sum,
                                                  input int shift,
                                                  input int d_width,
                                                  input logic relu);
      logic signed [63:0] t;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      t = sum;
      if (shift > 0) t = t + (64'sd1 <<< (shift - 1));
      t  = t >>> shift;
      hi = (64'sd1 <<< (d_width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (d_width - 1));
      if (t > hi)      t = hi;
      else if (t < lo) t = lo;
      if (relu && (t < 64'sd0)) t = 64'sd0;
      return t[31:0];
   endfunction

endpackage

// File: rtl/packed_mac_accumulator_lane.sv
// mac_lane_requant: one signed lane of the accumulator.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   accept       beat accepted this cycle (never asserted while stalled)
//   first, last  beat is first / last of its run
//   req_load     move the sum stage through requant into d
//   lane         signed product lane
//   bias         signed bias, used only on a first beat
//   d            requantized output for this lane
module mac_lane_requant
   import packed_mac_accumulator_pkg::*;
#(
   parameter int LANE_W = 16,
   parameter int ACC_W  = 32,
   parameter int D_W    = 8,
   parameter int SHIFT  = 8,
   parameter int RELU   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     accept,
   input  logic                     first,
   input  logic                     last,
   input  logic                     req_load,
   input  logic signed [LANE_W-1:0] lane,
   input  logic signed [ACC_W-1:0]  bias,
   output logic        [D_W-1:0]    d
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] lane_x;
   logic signed [ACC_W-1:0] next;
   logic signed [31:0]      r;

   assign lane_x = {{(ACC_W-LANE_W){lane[LANE_W-1]}}, lane};
   // First beat restarts from bias, so a leftover acc never leaks into a new run.
   assign next   = (first ? bias : acc) + lane_x;
   assign r      = requant(64'(sum), SHIFT, D_W, RELU != 0);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         sum <= '0;
         d   <= '0;
      end else begin
         if (accept)          acc <= next;
         if (accept && last)  sum <= next;
         if (req_load)        d   <= r[D_W-1:0];
      end
   end

endmodule

// File: rtl/packed_mac_accumulator.sv
// packed_mac_accumulator: splits a packed two-lane product word, accumulates
// each lane over a run (bias on the first beat), requantizes and emits the
// packed result on a valid/ready interface.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_i               packed product {lane1, lane0}
//   bias_i            {bias1, bias0}, sampled on a run's first beat
//   valid_i, last_i   beat valid, final beat of run
//   ready_o           beat accepted when valid_i & ready_o
//   d_o, valid_o      {lane1, lane0} result and its valid
//   ready_i           downstream accepts d_o
module packed_mac_accumulator
   import packed_mac_accumulator_pkg::*;
#(
   parameter int M_WIDTH    = 32,
   parameter int LANE_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int D_WIDTH    = 8,
   parameter int SHIFT      = 8,
   parameter int RELU       = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [M_WIDTH-1:0]     m_i,
   input  logic [2*ACC_WIDTH-1:0] bias_i,
   input  logic                   valid_i,
   input  logic                   last_i,
   output logic                   ready_o,
   output logic [2*D_WIDTH-1:0]   d_o,
   output logic                   valid_o,
   input  logic                   ready_i
);

   logic       stall;
   logic       accept;
   logic       first;
   logic       sum_valid;
   logic       req_load;
   lane_pair_t lp;

   logic [NUM_LANES-1:0][LANE_WIDTH-1:0] lanes;
   logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  biases;
   logic [NUM_LANES-1:0][D_WIDTH-1:0]    ds;

   assign stall    = valid_o & ~ready_i;
   assign ready_o  = ~stall;
   assign accept   = valid_i & ready_o;
   assign req_load = sum_valid & ~stall;

   assign lp     = lane_split(m_i);
   assign lanes  = {lp.lane1, lp.lane0};
   assign biases = bias_i;
   assign d_o    = ds;

   // Whole pipeline freezes on stall; otherwise each stage simply advances,
   // which gives 1 result/cycle and drops valid_o after a handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         first     <= 1'b1;
         sum_valid <= 1'b0;
         valid_o   <= 1'b0;
      end else if (!stall) begin
         sum_valid <= accept & last_i;
         valid_o   <= sum_valid;
         if (accept) first <= last_i;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      mac_lane_requant #(
         .LANE_W (LANE_WIDTH),
         .ACC_W  (ACC_WIDTH),
         .D_W    (D_WIDTH),
         .SHIFT  (SHIFT),
         .RELU   (RELU)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .accept   (accept),
         .first    (first),
         .last     (last_i),
         .req_load (req_load),
         .lane     (lanes[g]),
         .bias     (biases[g]),
         .d        (ds[g])
      );
   end

endmodule
